// File: rtl/solo_scheduler.sv
// Round-robin solo-slot scheduler: grants one guitarist at a time, bounds each
// solo with a cycle timer and inserts a fixed idle gap between solos.
module solo_scheduler #(
    parameter int N        = 4,
    parameter int SOLO_MAX = 8,
    parameter int GAP      = 1,
    localparam int ID_W    = $clog2(N),
    localparam int CNT_W   = $clog2(SOLO_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     grant,
    output logic             solo_active,
    output logic [ID_W-1:0]  solo_owner,
    output logic [CNT_W-1:0] remaining,
    output logic             timeout_pulse
);

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, SOLO, GAP_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic             active_reg, active_next;
    logic [ID_W-1:0]  owner_reg, owner_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             timeout_reg, timeout_next;
    logic [ID_W-1:0]  ptr_reg, ptr_next;
    logic [GAP_W-1:0] gap_reg, gap_next;

    logic [ID_W-1:0]  sel;
    logic             found;
    logic             owner_done, owner_drop, expire, solo_end;

    // First requester at or after the round-robin pointer, wrapping modulo N.
    always_comb begin
        sel   = ptr_reg;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_reg) + k) % N]) begin
                found = 1'b1;
                sel   = ID_W'((int'(ptr_reg) + k) % N);
            end
        end
    end

    assign owner_done = done[owner_reg];
    assign owner_drop = !req[owner_reg];
    assign expire     = (remaining_reg == CNT_W'(1));
    assign solo_end   = owner_done || owner_drop || expire;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        active_next    = active_reg;
        owner_next     = owner_reg;
        remaining_next = remaining_reg;
        timeout_next   = 1'b0;
        ptr_next       = ptr_reg;
        gap_next       = gap_reg;

        unique case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next     = SOLO;
                    grant_next     = {{(N-1){1'b0}}, 1'b1} << sel;
                    active_next    = 1'b1;
                    owner_next     = sel;
                    remaining_next = CNT_W'(SOLO_MAX);
                end
            end
            SOLO: begin
                if (solo_end) begin
                    grant_next     = '0;
                    active_next    = 1'b0;
                    remaining_next = '0;
                    ptr_next       = (owner_reg == ID_W'(N - 1)) ? '0 : owner_reg + 1'b1;
                    // Timer expiry only counts when the owner did not also finish or withdraw.
                    timeout_next   = expire && !owner_done && !owner_drop;
                    if (GAP > 0) begin
                        state_next = GAP_WAIT;
                        gap_next   = GAP_W'(GAP);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    remaining_next = remaining_reg - 1'b1;
                end
            end
            GAP_WAIT: begin
                if (gap_reg <= GAP_W'(1)) begin
                    state_next = IDLE;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            active_reg    <= 1'b0;
            owner_reg     <= '0;
            remaining_reg <= '0;
            timeout_reg   <= 1'b0;
            ptr_reg       <= '0;
            gap_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            active_reg    <= active_next;
            owner_reg     <= owner_next;
            remaining_reg <= remaining_next;
            timeout_reg   <= timeout_next;
            ptr_reg       <= ptr_next;
            gap_reg       <= gap_next;
        end
    end

    assign grant         = grant_reg;
    assign solo_active   = active_reg;
    assign solo_owner    = owner_reg;
    assign remaining     = remaining_reg;
    assign timeout_pulse = timeout_reg;

endmodule

// File: tb/tb_solo_scheduler.sv
// Self-checking bench for solo_scheduler (N=4, SOLO_MAX=8, GAP=1): table-driven
// arbitration sequences plus hand-written corner cases, checked through a queue.
module tb_solo_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] grant;
    logic       solo_active;
    logic [1:0] solo_owner;
    logic [3:0] remaining;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;
    string test_name = "";

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [3:0] rem;
        logic       to;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    solo_scheduler #(.N(4), .SOLO_MAX(8), .GAP(1)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .done(done),
        .grant(grant),
        .solo_active(solo_active),
        .solo_owner(solo_owner),
        .remaining(remaining),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got %0h want %0h", test_name, name, got, want);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic add_vec(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                           input logic [3:0] rem, input logic to, input logic [1:0] own);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.rem = rem; v.to = to; v.owner = own;
        tbl.push_back(v);
    endtask

    // Full-length solo ending on the timer, followed by the gap cycle.
    task automatic add_timeout_solo(input logic [3:0] r, input int own);
        for (int i = 0; i < 8; i++) add_vec(r, 4'b0, oh(own), 4'(8 - i), 1'b0, 2'(own));
        add_vec(r, 4'b0, 4'b0, 4'd0, 1'b1, 2'(own));
        add_vec(r, 4'b0, 4'b0, 4'd0, 1'b0, 2'(own));
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic cyc(input vec_t v);
        vec_t e;
        req  = v.req;
        done = v.done;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("grant", 8'(grant), 8'(e.grant));
        check("solo_active", 8'(solo_active), 8'(e.grant != 4'b0));
        check("remaining", 8'(remaining), 8'(e.rem));
        check("timeout_pulse", 8'(timeout_pulse), 8'(e.to));
        check("solo_owner", 8'(solo_owner), 8'(e.owner));
        $display("%s: req=%b done=%b grant=%b rem=%0d to=%b owner=%0d",
                 test_name, v.req, v.done, grant, remaining, timeout_pulse, solo_owner);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                        input logic [3:0] rem, input logic to, input logic [1:0] own);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.rem = rem; v.to = to; v.owner = own;
        cyc(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);
        tbl.delete();
    endtask

    task automatic check_reset_state();
        check("rst_grant", 8'(grant), 8'h0);
        check("rst_solo_active", 8'(solo_active), 8'h0);
        check("rst_remaining", 8'(remaining), 8'h0);
        check("rst_timeout", 8'(timeout_pulse), 8'h0);
        check("rst_owner", 8'(solo_owner), 8'h0);
    endtask

    task automatic do_reset(input string name);
        test_name = name;
        req = '0;
        done = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
    endtask

    initial begin
        // Single requester: 8-cycle solo, timeout pulse, two low cycles, re-grant.
        do_reset("single");
        add_timeout_solo(4'b0001, 0);
        add_vec(4'b0001, 4'b0, 4'b0001, 4'd8, 1'b0, 2'd0);
        run_table();

        // Full contention: rotating grants 0,1,2,3,0.
        do_reset("contention");
        for (int o = 0; o < 4; o++) add_timeout_solo(4'b1111, o);
        for (int i = 0; i < 8; i++) add_vec(4'b1111, 4'b0, 4'b0001, 4'(8 - i), 1'b0, 2'd0);
        run_table();

        // Early finish by owner 2 at remaining=6, then owner 3 wins from ptr=3.
        do_reset("early_done");
        step(4'b0100, 4'b0000, 4'b0100, 4'd8, 1'b0, 2'd2);
        step(4'b1111, 4'b0000, 4'b0100, 4'd7, 1'b0, 2'd2);
        step(4'b1111, 4'b0000, 4'b0100, 4'd6, 1'b0, 2'd2);
        step(4'b1111, 4'b0100, 4'b0000, 4'd0, 1'b0, 2'd2);
        step(4'b1011, 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd2);
        step(4'b1011, 4'b0000, 4'b1000, 4'd8, 1'b0, 2'd3);

        // Non-owner done and done during the gap are ignored.
        do_reset("ignored_done");
        for (int i = 0; i < 8; i++)
            step(4'b0001, (i == 3) ? 4'b0010 : 4'b0000, 4'b0001, 4'(8 - i), 1'b0, 2'd0);
        step(4'b0001, 4'b0000, 4'b0000, 4'd0, 1'b1, 2'd0);
        step(4'b0001, 4'b0001, 4'b0000, 4'd0, 1'b0, 2'd0);
        step(4'b0001, 4'b0000, 4'b0001, 4'd8, 1'b0, 2'd0);

        // Owner withdraws at remaining=5: no timeout pulse, scheduler goes quiet.
        do_reset("withdraw");
        for (int i = 0; i < 4; i++) step(4'b0001, 4'b0, 4'b0001, 4'(8 - i), 1'b0, 2'd0);
        step(4'b0000, 4'b0, 4'b0000, 4'd0, 1'b0, 2'd0);
        step(4'b0000, 4'b0, 4'b0000, 4'd0, 1'b0, 2'd0);
        step(4'b0000, 4'b0, 4'b0000, 4'd0, 1'b0, 2'd0);

        // done coincident with remaining=1 suppresses the timeout pulse.
        do_reset("done_at_one");
        for (int i = 0; i < 8; i++) step(4'b0010, 4'b0, 4'b0010, 4'(8 - i), 1'b0, 2'd1);
        step(4'b0010, 4'b0010, 4'b0000, 4'd0, 1'b0, 2'd1);
        step(4'b0000, 4'b0000, 4'b0000, 4'd0, 1'b0, 2'd1);

        // Asynchronous reset at remaining=4, then arbitration restarts from ptr=0.
        do_reset("async_reset");
        for (int i = 0; i < 5; i++) step(4'b0100, 4'b0, 4'b0100, 4'(8 - i), 1'b0, 2'd2);
        reset = 1'b1;
        #1;
        check_reset_state();
        $display("%s: reset asserted mid-solo grant=%b rem=%0d", test_name, grant, remaining);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b1111, 4'b0, 4'b0001, 4'd8, 1'b0, 2'd0);
        step(4'b1111, 4'b0, 4'b0001, 4'd7, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
